// File: rtl/tdc_spi_arbiter.sv
// tdc_spi_arbiter: shares one SPI byte master between the TDC (port 0) and aux (port 1) requesters,
// granting whole CS frames round-robin and force-releasing frames whose owner stalls.
module tdc_spi_arbiter #(
    parameter int LOCK_TIMEOUT = 1000,
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m0_start,
    input  logic [7:0] m0_mosi,
    input  logic       m0_cs_end,
    output logic       m0_busy,
    output logic [7:0] m0_miso,
    output logic       m0_new_data,
    input  logic       m1_start,
    input  logic [7:0] m1_mosi,
    input  logic       m1_cs_end,
    output logic       m1_busy,
    output logic [7:0] m1_miso,
    output logic       m1_new_data,
    output logic       spi_start,
    output logic [7:0] spi_mosi,
    output logic       spi_cs_end,
    output logic       spi_sel,
    input  logic       spi_busy,
    input  logic [7:0] spi_miso,
    input  logic       spi_new_data,
    output logic       lock_timeout
);
    typedef enum logic [1:0] {IDLE, ISSUE, XFER, HOLD} state_t;
    state_t           state;
    logic             grant;
    logic             last_served;
    logic [1:0]       pend;
    logic [1:0]       cse;
    logic [7:0]       dat [2];
    logic [CNT_W-1:0] cnt;
    logic [1:0]       start;
    logic [1:0]       cse_in;
    logic [7:0]       mosi_in [2];
    logic             pick;
    logic             active;
    assign start      = {m1_start, m0_start};
    assign cse_in     = {m1_cs_end, m0_cs_end};
    assign mosi_in[0] = m0_mosi;
    assign mosi_in[1] = m1_mosi;
    assign pick       = (pend == 2'b11) ? ~last_served : pend[1];
    assign active     = (state == ISSUE) || (state == XFER);
    assign m0_busy    = pend[0] | (~grant & active);
    assign m1_busy    = pend[1] | (grant & active);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            grant        <= 1'b0;
            last_served  <= 1'b1;
            pend         <= '0;
            cse          <= '0;
            dat[0]       <= '0;
            dat[1]       <= '0;
            cnt          <= '0;
            spi_start    <= 1'b0;
            spi_mosi     <= '0;
            spi_cs_end   <= 1'b0;
            spi_sel      <= 1'b0;
            m0_miso      <= '0;
            m1_miso      <= '0;
            m0_new_data  <= 1'b0;
            m1_new_data  <= 1'b0;
            lock_timeout <= 1'b0;
        end else begin
            spi_start    <= 1'b0;
            m0_new_data  <= 1'b0;
            m1_new_data  <= 1'b0;
            lock_timeout <= 1'b0;
            for (int i = 0; i < 2; i++)
                if (start[i] && !pend[i]) begin
                    pend[i] <= 1'b1;
                    dat[i]  <= mosi_in[i];
                    cse[i]  <= cse_in[i];
                end
            case (state)
                IDLE:
                    if (!spi_busy && pend != 2'b00) begin
                        grant      <= pick;
                        spi_sel    <= pick;
                        spi_mosi   <= dat[pick];
                        spi_cs_end <= cse[pick];
                        spi_start  <= 1'b1;
                        state      <= ISSUE;
                    end
                ISSUE: begin
                    pend[grant] <= 1'b0;
                    state       <= XFER;
                end
                XFER:
                    if (spi_new_data) begin
                        if (grant) begin
                            m1_miso     <= spi_miso;
                            m1_new_data <= 1'b1;
                        end else begin
                            m0_miso     <= spi_miso;
                            m0_new_data <= 1'b1;
                        end
                        // spi_cs_end still holds the issued byte's flag; the holding register may already carry the next byte
                        if (spi_cs_end) begin
                            last_served <= grant;
                            state       <= IDLE;
                        end else begin
                            cnt   <= '0;
                            state <= HOLD;
                        end
                    end
                HOLD:
                    if (pend[grant] && !spi_busy) begin
                        spi_mosi   <= dat[grant];
                        spi_cs_end <= cse[grant];
                        spi_start  <= 1'b1;
                        state      <= ISSUE;
                    end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        lock_timeout <= 1'b1;
                        last_served  <= grant;
                        state        <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tdc_spi_arbiter.sv
// tb_tdc_spi_arbiter: directed table, frame/contention/timeout/reset sequences and a randomized run against a queue model.
module tb_tdc_spi_arbiter;
    localparam int LT = 20;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m0_start = 1'b0, m1_start = 1'b0;
    logic [7:0] m0_mosi = '0, m1_mosi = '0;
    logic       m0_cs_end = 1'b0, m1_cs_end = 1'b0;
    logic       m0_busy, m1_busy, m0_new_data, m1_new_data;
    logic [7:0] m0_miso, m1_miso;
    logic       spi_start, spi_cs_end, spi_sel, lock_timeout;
    logic [7:0] spi_mosi;
    logic       spi_busy = 1'b0, spi_new_data = 1'b0;
    logic [7:0] spi_miso = '0;

    always #5 clk = ~clk;

    tdc_spi_arbiter #(.LOCK_TIMEOUT(LT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .m0_start(m0_start), .m0_mosi(m0_mosi), .m0_cs_end(m0_cs_end),
        .m0_busy(m0_busy), .m0_miso(m0_miso), .m0_new_data(m0_new_data),
        .m1_start(m1_start), .m1_mosi(m1_mosi), .m1_cs_end(m1_cs_end),
        .m1_busy(m1_busy), .m1_miso(m1_miso), .m1_new_data(m1_new_data),
        .spi_start(spi_start), .spi_mosi(spi_mosi), .spi_cs_end(spi_cs_end), .spi_sel(spi_sel),
        .spi_busy(spi_busy), .spi_miso(spi_miso), .spi_new_data(spi_new_data),
        .lock_timeout(lock_timeout)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {logic sel; logic [7:0] mosi; logic cse;} iss_t;
    iss_t       issued[$];
    bit         fix_en = 1'b0;
    logic [7:0] fix_val = '0;
    int         fix_lat = 1;
    bit         mact = 1'b0;
    bit         msel = 1'b0;
    int         mcnt = 0;
    int         done_p = -1;
    logic [7:0] ret_last [2];

    // one cycle: move to the next falling edge, end start pulses, advance the SPI master model
    task automatic tick();
        @(negedge clk);
        m0_start = 1'b0;
        m1_start = 1'b0;
        spi_new_data = 1'b0;
        done_p = -1;
        if (rst) begin
            mact = 1'b0;
            spi_busy = 1'b0;
        end else if (mact) begin
            mcnt--;
            if (mcnt == 0) begin
                spi_new_data = 1'b1;
                spi_miso = fix_en ? fix_val : 8'($urandom);
                ret_last[msel] = spi_miso;
                done_p = int'(msel);
                mact = 1'b0;
                spi_busy = 1'b0;
            end
        end else if (spi_start) begin
            mact = 1'b1;
            spi_busy = 1'b1;
            msel = spi_sel;
            mcnt = fix_en ? fix_lat : int'($urandom_range(1, 6));
            issued.push_back({spi_sel, spi_mosi, spi_cs_end});
        end
    endtask

    task automatic drive(input bit p, input logic [7:0] d, input logic c);
        if (p) begin
            m1_start = 1'b1; m1_mosi = d; m1_cs_end = c;
        end else begin
            m0_start = 1'b1; m0_mosi = d; m0_cs_end = c;
        end
    endtask

    function automatic logic busy_of(input bit p);
        return p ? m1_busy : m0_busy;
    endfunction
    function automatic logic nd_of(input bit p);
        return p ? m1_new_data : m0_new_data;
    endfunction
    function automatic logic [7:0] miso_of(input bit p);
        return p ? m1_miso : m0_miso;
    endfunction
    function automatic logic [31:0] all_out();
        return 32'({m0_busy, m1_busy, m0_miso, m1_miso, m0_new_data, m1_new_data,
                    spi_start, spi_mosi, spi_cs_end, spi_sel, lock_timeout});
    endfunction

    task automatic wait_start(output int k);
        k = 0;
        do begin tick(); k++; end while (!spi_start && k < 300);
        chk("spi_start_seen", 32'(spi_start), 1);
    endtask

    task automatic wait_nd(input bit p, output int k);
        k = 0;
        do begin tick(); k++; end while (!nd_of(p) && k < 300);
        chk("new_data_seen", 32'(nd_of(p)), 1);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    typedef struct {bit p; logic [7:0] d; logic [7:0] r; int lat;} vec_t;
    vec_t vt [5];

    initial begin
        int k, n;
        logic [7:0] fb [4];
        vt[0] = '{1'b0, 8'hA5, 8'h3C, 8};
        vt[1] = '{1'b1, 8'h5A, 8'hC3, 3};
        vt[2] = '{1'b0, 8'h00, 8'hFF, 1};
        vt[3] = '{1'b1, 8'hFF, 8'h00, 5};
        vt[4] = '{1'b0, 8'h81, 8'h7E, 2};

        tick();
        chk("reset_outputs", all_out(), 0);
        rst = 1'b0;
        tick();
        chk("post_reset_idle", all_out(), 0);

        spi_new_data = 1'b1;
        spi_miso = 8'hFF;
        tick();
        chk("stray_new_data", 32'({m0_new_data, m1_new_data, m0_miso, m1_miso}), 0);

        fix_en = 1'b1;
        foreach (vt[i]) begin
            fix_val = vt[i].r;
            fix_lat = vt[i].lat;
            drive(vt[i].p, vt[i].d, 1'b1);
            tick();
            chk("busy_after_start", 32'(busy_of(vt[i].p)), 1);
            tick();
            chk("issue_latency", 32'(spi_start), 1);
            chk("issue_byte", 32'({spi_sel, spi_mosi, spi_cs_end}), 32'({vt[i].p, vt[i].d, 1'b1}));
            wait_nd(vt[i].p, k);
            chk("done_latency", 32'(k), 32'(vt[i].lat + 1));
            chk("miso", 32'(miso_of(vt[i].p)), 32'(vt[i].r));
            chk("busy_cleared", 32'(busy_of(vt[i].p)), 0);
            tick();
            chk("new_data_single", 32'(nd_of(vt[i].p)), 0);
        end

        fix_en = 1'b0;
        reset_dut();
        for (int r = 0; r < 2; r++) begin
            drive(1'b0, 8'h10, 1'b1);
            drive(1'b1, 8'h20, 1'b1);
            wait_start(k);
            chk("tie_first_sel", 32'(spi_sel), 0);
            wait_nd(1'b0, k);
            wait_start(k);
            chk("tie_second_sel", 32'(spi_sel), 1);
            wait_nd(1'b1, k);
        end

        issued.delete();
        fb = '{8'h11, 8'h22, 8'h33, 8'h44};
        drive(1'b0, fb[0], 1'b0);
        wait_start(k);
        chk("frame_first_latency", 32'(k), 2);
        drive(1'b1, 8'h99, 1'b1);
        wait_nd(1'b0, k);
        for (int i = 1; i < 4; i++) begin
            drive(1'b0, fb[i], i == 3);
            wait_start(k);
            chk("frame_next_latency", 32'(k), 2);
            wait_nd(1'b0, k);
        end
        wait_start(k);
        chk("contender_after_frame", 32'(spi_sel), 1);
        wait_nd(1'b1, k);
        chk("frame_issue_count", 32'(issued.size()), 5);
        for (int i = 0; i < 4; i++)
            chk("frame_byte", 32'(issued[i]), 32'({1'b0, fb[i], i == 3}));
        chk("contender_byte", 32'(issued[4]), 32'({1'b1, 8'h99, 1'b1}));

        drive(1'b0, 8'h42, 1'b0);
        wait_start(k);
        wait_nd(1'b0, k);
        drive(1'b1, 8'h24, 1'b1);
        k = 0;
        do begin tick(); k++; chk("held_no_issue", 32'(spi_start), 0); end while (!lock_timeout && k < 60);
        chk("timeout_delay", 32'(k), LT);
        tick();
        chk("timeout_single", 32'(lock_timeout), 0);
        chk("post_timeout_issue", 32'({spi_start, spi_sel, spi_mosi}), 32'({1'b1, 1'b1, 8'h24}));
        wait_nd(1'b1, k);

        fix_en = 1'b1;
        fix_val = 8'h6B;
        fix_lat = 10;
        drive(1'b1, 8'h5A, 1'b1);
        wait_start(k);
        tick();
        drive(1'b0, 8'h77, 1'b1);
        tick();
        chk("pending_before_reset", 32'(m0_busy), 1);
        rst = 1'b1;
        #1;
        chk("reset_mid_xfer", all_out(), 0);
        tick();
        rst = 1'b0;
        issued.delete();
        tick();
        drive(1'b1, 8'hC3, 1'b1);
        wait_start(k);
        chk("restart_latency", 32'(k), 2);
        chk("restart_byte", 32'({spi_sel, spi_mosi}), 32'({1'b1, 8'hC3}));
        wait_nd(1'b1, k);
        repeat (25) tick();
        chk("lost_pending", 32'({m0_busy, 8'(issued.size())}), 1);

        issued.delete();
        drive(1'b1, 8'hA1, 1'b1);
        tick();
        drive(1'b1, 8'hB2, 1'b1);
        n = 0;
        repeat (30) begin tick(); if (m1_new_data) n++; end
        chk("double_start_nd", 32'(n), 1);
        chk("double_start_issues", 32'(issued.size()), 1);
        chk("double_start_byte", 32'(issued[0].mosi), 32'(8'hA1));

        begin
            bit out [2];
            logic [8:0] eq [2][$];
            logic [8:0] e;
            int prev_done;
            bit own_v, own;
            fix_en = 1'b0;
            reset_dut();
            out = '{1'b0, 1'b0};
            prev_done = -1;
            own_v = 1'b0;
            own = 1'b0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                tick();
                chk("rnd_busy0", 32'(m0_busy), 32'(out[0]));
                chk("rnd_busy1", 32'(m1_busy), 32'(out[1]));
                chk("rnd_nd0", 32'(m0_new_data), 32'(prev_done == 0));
                chk("rnd_nd1", 32'(m1_new_data), 32'(prev_done == 1));
                if (m0_new_data) chk("rnd_miso0", 32'(m0_miso), 32'(ret_last[0]));
                if (m1_new_data) chk("rnd_miso1", 32'(m1_miso), 32'(ret_last[1]));
                if (spi_start) begin
                    if (own_v) chk("rnd_frame_lock", 32'(spi_sel), 32'(own));
                    e = 'x;
                    if (eq[spi_sel].size() > 0) e = eq[spi_sel].pop_front();
                    chk("rnd_issue_byte", 32'({spi_cs_end, spi_mosi}), 32'(e));
                    own_v = !spi_cs_end;
                    own = spi_sel;
                end
                if (lock_timeout) own_v = 1'b0;
                prev_done = done_p;
                if (done_p >= 0) out[done_p] = 1'b0;
                if (cyc < 2800)
                    for (int p = 0; p < 2; p++)
                        if (!out[p] && $urandom_range(0, 3) == 0) begin
                            e = 9'($urandom);
                            e[8] = ($urandom_range(0, 2) == 0);
                            drive(p[0], e[7:0], e[8]);
                            eq[p].push_back(e);
                            out[p] = 1'b1;
                        end
            end
            chk("rnd_drain0", 32'(eq[0].size()), 0);
            chk("rnd_drain1", 32'(eq[1].size()), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
